// File: rtl/logicgates_mux_checker_pkg.sv
// gate_check_pkg: shared types and helpers for the mux-built gate checker.
//   state_e        : checker FSM states
//   NUM_VECTORS    : exhaustive 2-input sweep length
//   G_*            : bit positions of each gate output inside y[5:0]
//   gate_expected  : golden 6-bit response for a given (a,b)
package gate_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam int NUM_VECTORS = 4;

    localparam int G_AND  = 0;
    localparam int G_OR   = 1;
    localparam int G_NAND = 2;
    localparam int G_NOR  = 3;
    localparam int G_XOR  = 4;
    localparam int G_XNOR = 5;

    function automatic logic [5:0] gate_expected(input logic a, input logic b);
        logic [5:0] e;
        e         = '0;
        e[G_AND]  = a & b;
        e[G_OR]   = a | b;
        e[G_NAND] = ~(a & b);
        e[G_NOR]  = ~(a | b);
        e[G_XOR]  = a ^ b;
        e[G_XNOR] = ~(a ^ b);
        return e;
    endfunction

endpackage

// File: rtl/logicgates_mux_checker_if.sv
// logicgates_mux_checker_if: stimulus/response bus between the checker and
// its user.
//   start            : request a sweep
//   y[5:0]           : gate block response {xnor,xor,nor,nand,or,and}
//   a, b             : stimulus bits
//   busy, done, pass : sweep status / verdict
//   sample_valid     : one-cycle pulse after each sample edge
//   err_count        : failing vectors (saturating, ERR_W bits)
//   first_fail_vec   : {a,b} of first failing vector
//   first_fail_mask  : y ^ expected at first failure
// master = checker side, slave = the side issuing start / returning y.
interface logicgates_mux_checker_if #(
    parameter int ERR_W = 4
);
    logic             start;
    logic [5:0]       y;
    logic             a;
    logic             b;
    logic             busy;
    logic             done;
    logic             pass;
    logic             sample_valid;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       first_fail_vec;
    logic [5:0]       first_fail_mask;

    modport master (
        input  start, y,
        output a, b, busy, done, pass, sample_valid,
               err_count, first_fail_vec, first_fail_mask
    );

    modport slave (
        output start, y,
        input  a, b, busy, done, pass, sample_valid,
               err_count, first_fail_vec, first_fail_mask
    );
endinterface

// File: rtl/logicgates_mux_checker_gate_golden_model.sv
// gate_golden_model: combinational reference for the six 2-input gates.
//   a, b          : stimulus
//   expected[5:0] : {xnor,xor,nor,nand,or,and} of (a,b)
module gate_golden_model
    import gate_check_pkg::*;
(
    input  logic       a,
    input  logic       b,
    output logic [5:0] expected
);
    assign expected = gate_expected(a, b);
endmodule

// File: rtl/logicgates_mux_checker.sv
// logicgates_mux_checker: drives the four (a,b) combinations into the gate
// block, holds each for SETTLE_CYCLES, samples y on the last cycle and
// compares it against the golden model; reports pass/fail and statistics.
//   clk : clock (rising edge)
//   rst : asynchronous active-high reset
//   bus : master side of logicgates_mux_checker_if
module logicgates_mux_checker
    import gate_check_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,   // 1..15
    parameter int ERR_W         = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    logicgates_mux_checker_if.master      bus
);

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [1:0] LAST_VEC = 2'(NUM_VECTORS - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q;
    logic             a_q, b_q;
    logic             busy_q, done_q, pass_q, sv_q;
    logic [ERR_W-1:0] err_q;
    logic [1:0]       ffv_q;
    logic [5:0]       ffm_q;

    logic [5:0]       expected;
    logic [5:0]       diff;
    logic             mismatch;
    logic             start_ok;
    logic             sample;
    logic             last_vec;

    gate_golden_model u_golden (
        .a        (a_q),
        .b        (b_q),
        .expected (expected)
    );

    // Vector index is {a,b} itself; no separate index register needed.
    assign diff     = bus.y ^ expected;
    assign mismatch = |diff;
    assign start_ok = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign sample   = (state_q == ST_SETTLE) && (cnt_q == 4'd0);
    assign last_vec = ({a_q, b_q} == LAST_VEC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (bus.start)          state_d = ST_SETTLE;
            ST_SETTLE:        if (sample && last_vec) state_d = ST_DONE;
            default:                                  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            sv_q   <= 1'b0;
            err_q  <= '0;
            ffv_q  <= '0;
            ffm_q  <= '0;
        end else begin
            sv_q <= sample;
            if (start_ok) begin
                cnt_q  <= CNT_INIT;
                a_q    <= 1'b0;
                b_q    <= 1'b0;
                busy_q <= 1'b1;
                done_q <= 1'b0;
                pass_q <= 1'b0;
                err_q  <= '0;
                ffv_q  <= '0;
                ffm_q  <= '0;
            end else if (state_q == ST_SETTLE) begin
                if (!sample) begin
                    cnt_q <= cnt_q - 4'd1;
                end else begin
                    if (mismatch) begin
                        if (err_q != '1) err_q <= err_q + ERR_W'(1);
                        // err_q never returns to zero mid-sweep, so zero
                        // means no earlier failure.
                        if (err_q == '0) begin
                            ffv_q <= {a_q, b_q};
                            ffm_q <= diff;
                        end
                    end
                    if (!last_vec) begin
                        {a_q, b_q} <= {a_q, b_q} + 2'd1;
                        cnt_q      <= CNT_INIT;
                    end else begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= (err_q == '0) && !mismatch;
                    end
                end
            end
        end
    end

    assign bus.a               = a_q;
    assign bus.b               = b_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = pass_q;
    assign bus.sample_valid    = sv_q;
    assign bus.err_count       = err_q;
    assign bus.first_fail_vec  = ffv_q;
    assign bus.first_fail_mask = ffm_q;

endmodule

// File: tb/tb_logicgates_mux_checker.sv
// Bench: two checker instances (S=2/ERR_W=4 and S=1/ERR_W=1) each driving an
// emulated gate block whose response is the true gate function XOR a
// per-vector fault mask chosen by the bench. A timeline model predicts every
// output from "cycles since accepted start" and the masks seen at sample time.
module tb_logicgates_mux_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logicgates_mux_checker_if #(.ERR_W(4)) if0 ();
    logicgates_mux_checker_if #(.ERR_W(1)) if1 ();

    logicgates_mux_checker #(.SETTLE_CYCLES(2), .ERR_W(4)) u0 (
        .clk (clk), .rst (rst), .bus (if0)
    );
    logicgates_mux_checker #(.SETTLE_CYCLES(1), .ERR_W(1)) u1 (
        .clk (clk), .rst (rst), .bus (if1)
    );

    // fault masks indexed by vector {a,b}
    logic [3:0][5:0] fm0 = '0;
    logic [3:0][5:0] fm1 = '0;

    function automatic logic [5:0] truth(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
    endfunction

    assign if0.y = truth(if0.a, if0.b) ^ fm0[{if0.a, if0.b}];
    assign if1.y = truth(if1.a, if1.b) ^ fm1[{if1.a, if1.b}];

    logic start = 1'b0;
    assign if0.start = start;
    assign if1.start = start;

    // ---------------- timeline model ----------------
    typedef struct packed {
        logic       a, b, busy, done, pass, sv;
        logic [1:0] ffv;
        logic [5:0] ffm;
        int         err;
    } exp_t;

    bit              st0 = 0, st1 = 0;
    int              t0 = 0, t1 = 0;
    logic [3:0][5:0] rec0 = '0, rec1 = '0;

    function automatic exp_t model(int s, int ew, bit started, int t,
                                   logic [3:0][5:0] rec);
        exp_t e;
        int   n;
        bit   anyf;
        e    = '0;
        anyf = 0;
        if (!started) return e;
        n = t / s;
        if (n > 4) n = 4;
        for (int k = 0; k < n; k++) begin
            if (rec[k] != 6'd0) begin
                if (!anyf) begin
                    e.ffv = 2'(k);
                    e.ffm = rec[k];
                end
                anyf = 1;
                if (e.err < (1 << ew) - 1) e.err++;
            end
        end
        if (t < 4 * s) begin
            e.busy       = 1'b1;
            {e.a, e.b}   = 2'(t / s);
            e.sv         = (t > 0) && (t % s == 0);
        end else begin
            e.a    = 1'b1;
            e.b    = 1'b1;
            e.done = 1'b1;
            e.pass = !anyf;
            e.sv   = (t == 4 * s);
        end
        return e;
    endfunction

    // vector k is sampled at t == (k+1)*S; remember the mask in force then
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            st0 <= 0;
            t0  <= 0;
        end else if (start && (!st0 || t0 >= 8)) begin
            st0 <= 1;
            t0  <= 0;
        end else if (st0 && t0 < 9) begin
            t0 <= t0 + 1;
            if ((t0 + 1) % 2 == 0 && (t0 + 1) / 2 <= 4)
                rec0[(t0 + 1) / 2 - 1] <= fm0[(t0 + 1) / 2 - 1];
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            st1 <= 0;
            t1  <= 0;
        end else if (start && (!st1 || t1 >= 4)) begin
            st1 <= 1;
            t1  <= 0;
        end else if (st1 && t1 < 5) begin
            t1 <= t1 + 1;
            if (t1 + 1 <= 4) rec1[t1] <= fm1[t1];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_all(input string p, input exp_t e,
                           input logic a, input logic b, input logic busy,
                           input logic done, input logic pass, input logic sv,
                           input logic [31:0] err, input logic [1:0] ffv,
                           input logic [5:0] ffm);
        chk({p, ".a"},    a,    e.a);
        chk({p, ".b"},    b,    e.b);
        chk({p, ".busy"}, busy, e.busy);
        chk({p, ".done"}, done, e.done);
        chk({p, ".pass"}, pass, e.pass);
        chk({p, ".sv"},   sv,   e.sv);
        chk({p, ".err"},  err,  e.err);
        chk({p, ".ffv"},  ffv,  e.ffv);
        chk({p, ".ffm"},  ffm,  e.ffm);
    endtask

    always @(negedge clk) begin
        cmp_all("u0", model(2, 4, st0, t0, rec0), if0.a, if0.b, if0.busy,
                if0.done, if0.pass, if0.sample_valid, 32'(if0.err_count),
                if0.first_fail_vec, if0.first_fail_mask);
        cmp_all("u1", model(1, 1, st1, t1, rec1), if1.a, if1.b, if1.busy,
                if1.done, if1.pass, if1.sample_valid, 32'(if1.err_count),
                if1.first_fail_vec, if1.first_fail_mask);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [5:0] rand_mask();
        if ($urandom_range(0, 1) == 0) return 6'd0;
        return 6'($urandom_range(1, 63));
    endfunction

    int svc;

    initial begin
        repeat (3) tick();
        // reset state
        chk("rst.a",    if0.a, 1'b0);
        chk("rst.busy", if0.busy, 1'b0);
        chk("rst.done", if0.done, 1'b0);
        chk("rst.err",  32'(if0.err_count), 0);
        rst = 1'b0;
        tick();

        // clean sweep with a start pulse mid-sweep that must be ignored
        pulse_start();
        svc = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            svc += int'(if0.sample_valid);
            if (i == 3) start = 1'b1;
            if (i == 4) start = 1'b0;
            if (i == 3) chk("u1.done@3", if1.done, 1'b0);
            if (i == 4) begin
                chk("u1.done@4", if1.done, 1'b1);
                chk("u1.pass@4", if1.pass, 1'b1);
            end
            if (i == 7) chk("u0.done@7", if0.done, 1'b0);
            if (i == 8) begin
                chk("u0.done@8", if0.done, 1'b1);
                chk("u0.pass@8", if0.pass, 1'b1);
                chk("u0.err@8",  32'(if0.err_count), 0);
                chk("u0.ab@8",   {if0.a, if0.b}, 2'b11);
            end
        end
        chk("u0.sv_pulses", svc, 4);

        // y5 stuck-at-0 on u0, all outputs inverted on u1 (ERR_W=1)
        fm0 = '0;
        fm0[1] = 6'b010000;
        fm0[2] = 6'b010000;
        fm1 = {4{6'h3f}};
        pulse_start();
        repeat (10) tick();
        chk("sa0.err",  32'(if0.err_count), 2);
        chk("sa0.ffv",  if0.first_fail_vec, 2'b01);
        chk("sa0.ffm",  if0.first_fail_mask, 6'b010000);
        chk("sa0.pass", if0.pass, 1'b0);
        chk("inv.err",  32'(if1.err_count), 1);
        chk("inv.ffv",  if1.first_fail_vec, 2'b00);
        chk("inv.ffm",  if1.first_fail_mask, 6'b111111);
        chk("inv.pass", if1.pass, 1'b0);

        // restart from DONE clears results
        fm0 = '0;
        fm1 = '0;
        pulse_start();
        chk("re.done", if0.done, 1'b0);
        chk("re.err",  32'(if0.err_count), 0);
        chk("re.ab",   {if0.a, if0.b}, 2'b00);
        chk("re.busy", if0.busy, 1'b1);
        repeat (10) tick();
        chk("re.pass", if0.pass, 1'b1);

        // async reset during vector 10
        fm0[0] = 6'b000001;
        pulse_start();
        repeat (4) tick();
        chk("mid.ab", {if0.a, if0.b}, 2'b10);
        #1 rst = 1'b1;
        #1;
        chk("mid.ab0",   {if0.a, if0.b}, 2'b00);
        chk("mid.busy",  if0.busy, 1'b0);
        chk("mid.err",   32'(if0.err_count), 0);
        chk("mid.ffm",   if0.first_fail_mask, 6'd0);
        tick();
        rst = 1'b0;
        fm0 = '0;
        tick();
        pulse_start();
        repeat (10) tick();
        chk("post.pass", if0.pass, 1'b1);
        chk("post.done", if0.done, 1'b1);

        // randomized sweeps with random fault masks and stray starts
        for (int it = 0; it < 30; it++) begin
            for (int k = 0; k < 4; k++) begin
                fm0[k] = rand_mask();
                fm1[k] = rand_mask();
            end
            pulse_start();
            for (int c = 0; c < 8 + int'($urandom_range(0, 4)); c++) begin
                start = ($urandom_range(0, 3) == 0);
                tick();
            end
            start = 1'b0;
            repeat (9) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/logicgates_mux_checker.md
# logicgates_mux_checker

Synthesizable self-checking stimulus/response engine for the two-input logic-gate block built from multiplexers: it drives `a`/`b` through all four input combinations and samples the block's six gate outputs. It compares them against a golden model and reports pass/fail with error statistics. It sits on the driving side of the gate block, either on-chip as a BIST-style checker or as the hardware counterpart of the simulation bench.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range 1..15.
- `ERR_W`, default 4: width of the error counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a sweep; sampled only in IDLE or DONE.
- `y`  in  6  DUT response `{y6,y5,y4,y3,y2,y1}`: y1 AND, y2 OR, y3 NAND, y4 NOR, y5 XOR, y6 XNOR.
- `a`  out  1  stimulus bit a (registered).
- `b`  out  1  stimulus bit b (registered).
- `busy`  out  1  high from accepted start until sweep completes.
- `done`  out  1  level; high in DONE until next accepted start or reset.
- `pass`  out  1  valid when `done`=1; 1 iff no vector mismatched.
- `sample_valid`  out  1  one-cycle pulse on each sample edge.
- `err_count`  out  ERR_W  failing vectors this sweep; saturates at 2^ERR_W-1.
- `first_fail_vec`  out  2  `{a,b}` of first failing vector.
- `first_fail_mask`  out  6  `y ^ expected` captured at first failure.

## Operation
- States: IDLE, SETTLE, DONE.
- IDLE/DONE with `start`=1: next state SETTLE.
  - Vector index = 0, so `{a,b}`=00.
  - Settle counter loaded with SETTLE_CYCLES-1.
  - `err_count`, `first_fail_*`, `pass` and `done` cleared.
- SETTLE:
  - Counter decrements each cycle.
  - On the edge where counter==0, capture `y` and compare with expected. Expected: `{~(a^b), a^b, ~(a|b), ~(a&b), a|b, a&b}`, using the currently driven `a`,`b`.
  - On that same edge, `sample_valid`=1 for the following cycle.
  - On mismatch (any bit of `y ^ expected` set): `err_count` += 1, saturating. If this is the first failure, load `first_fail_vec` and `first_fail_mask`.
  - After sampling vectors 0..2: increment the vector index, reload the counter, and drive the next vector on the same edge. Order is 00, 01, 10, 11, with a = index[1] and b = index[0].
  - After sampling vector 3: go to DONE, `busy`=0, `done`=1, `pass` = (no mismatch seen, including this vector).
- DONE: `a`,`b` hold 11; results hold until a new `start` or `rst`.
- `start` while in SETTLE is ignored and has no effect on timing or results.
- Error counting is per vector, not per bit.

## Timing
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `sample_valid`=0, `err_count`=0, `first_fail_vec`=0, `first_fail_mask`=0, state IDLE.
- Reset is asynchronous: asserting `rst` mid-sweep forces all outputs to reset values immediately, discarding partial results.
- Start accepted at edge E0: `busy`=1 and `{a,b}`=00 from E0.
- Vector k is driven from E0+k·S to E0+(k+1)·S, where S = SETTLE_CYCLES.
- Vector k is sampled at edge E0+(k+1)·S.
- `done`/`pass` are valid from edge E0+4·S.
- With default S=2: done 8 cycles after the start edge.
- `y` must be stable for at least 1 cycle before the sample edge; with S=1 the DUT path must be combinational within one cycle.

## Structure
- Shared package `gate_check_pkg`:
  - State enum.
  - `NUM_VECTORS`=4.
  - Gate bit-index constants (AND=0 … XNOR=5).
  - Function `gate_expected(a,b)` returning 6 bits.
- One sub-module is natural: `gate_golden_model`, combinational `a,b -> expected[5:0]`, instantiated once. The same model is reusable by the bench scoreboard.
- The remaining logic (FSM, counters, result registers) lives in the top module.

## Test plan
- Correct DUT, S=2 -> `{a,b}` = 00,01,10,11, each held 2 cycles; `done` at start+8; `pass`=1; `err_count`=0; four `sample_valid` pulses.
- DUT with y5 stuck-at-0 -> vectors 01 and 10 fail; `err_count`=2, `first_fail_vec`=01, `first_fail_mask`=6'b010000, `pass`=0.
- DUT with all outputs inverted, ERR_W=1 -> `err_count` saturates at 1, `first_fail_vec`=00, `first_fail_mask`=6'b111111.
- `start` pulsed at start+3 -> ignored, `done` still at start+8. A second `start` in DONE -> results cleared, new sweep from 00.
- `rst` asserted during vector 10 -> all outputs 0 immediately, state IDLE. Next `start` runs a full sweep from 00 with `pass`=1.
- S=1 with correct DUT -> one cycle per vector; `done` at start+4; `pass`=1.
